// File: rtl/mac_seq.sv
// Sequencer that drives an external registered MAC to produce one TAPS-tap FIR output per accepted sample.
// Optional macro MAC_SEQ_ZSKIP_EN: suppress the MAC update enable on ACC cycles whose coefficient is zero.
module mac_seq #(
  parameter int WIDTH      = 24,
  parameter int DATA_WIDTH = 12,
  parameter int TAPS       = 8,
  localparam int AW        = $clog2(TAPS)
) (
  input  logic                  Clk_CI,
  input  logic                  Rst_RBI,
  input  logic [DATA_WIDTH-1:0] In_DI,
  input  logic                  InValid_SI,
  output logic                  InReady_SO,
  input  logic                  CoefWrEn_SI,
  input  logic [AW-1:0]         CoefAddr_DI,
  input  logic [DATA_WIDTH-1:0] Coef_DI,
  output logic                  MacClr_SO,
  output logic                  MacWrEn_SO,
  output logic [DATA_WIDTH-1:0] MacIn0_DO,
  output logic [DATA_WIDTH-1:0] MacIn1_DO,
  input  logic [WIDTH-1:0]      MacOut_DI,
  output logic [WIDTH-1:0]      Out_DO,
  output logic                  OutValid_SO,
  input  logic                  OutReady_SI
);

  // Input handshake: a sample transfers on an edge where InValid_SI and InReady_SO are both 1.
  // Output handshake: a result transfers on an edge where OutValid_SO and OutReady_SI are both 1;
  // Out_DO is held stable while OutValid_SO waits for OutReady_SI.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_ACC   = 3'd2,
    S_CAPT  = 3'd3,
    S_OUT   = 3'd4
  } state_e;

  state_e                state_q;
  logic [AW-1:0]         wr_ptr_q;
  logic [AW-1:0]         tap_q;
  logic [AW-1:0]         tap_d;
  logic [AW-1:0]         samp_idx;
  logic [DATA_WIDTH-1:0] coef_q [TAPS];
  logic [DATA_WIDTH-1:0] samp_q [TAPS];
  logic                  ready_q;
  logic                  valid_q;
  logic                  clr_q;
  logic                  wren_q;
  logic [DATA_WIDTH-1:0] in0_q;
  logic [DATA_WIDTH-1:0] in1_q;
  logic [WIDTH-1:0]      out_q;
  logic                  in_hs;
  logic                  wren_d;

  // Operands for the next ACC cycle are registered one edge ahead, so the
  // sample address is computed from the tap index that is about to be used.
  always_comb begin
    tap_d = '0;
    if (state_q == S_ACC) begin
      tap_d = tap_q + AW'(1);
    end
    samp_idx = wr_ptr_q - AW'(1) - tap_d;
    in_hs    = InValid_SI & ready_q;
`ifdef MAC_SEQ_ZSKIP_EN
    wren_d   = |coef_q[tap_d];
`else
    wren_d   = 1'b1;
`endif
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      tap_q    <= '0;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
      clr_q    <= 1'b0;
      wren_q   <= 1'b0;
      in0_q    <= '0;
      in1_q    <= '0;
      out_q    <= '0;
      for (int i = 0; i < TAPS; i++) begin
        coef_q[i] <= '0;
        samp_q[i] <= '0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (CoefWrEn_SI) begin
            coef_q[CoefAddr_DI] <= Coef_DI;
          end
          if (in_hs) begin
            samp_q[wr_ptr_q] <= In_DI;
            wr_ptr_q         <= wr_ptr_q + AW'(1);
            state_q          <= S_CLEAR;
            ready_q          <= 1'b0;
            clr_q            <= 1'b1;
            wren_q           <= 1'b1;
            in0_q            <= '0;
            in1_q            <= '0;
          end
        end
        S_CLEAR: begin
          state_q <= S_ACC;
          tap_q   <= tap_d;
          clr_q   <= 1'b0;
          wren_q  <= wren_d;
          in0_q   <= samp_q[samp_idx];
          in1_q   <= coef_q[tap_d];
        end
        S_ACC: begin
          if (tap_q == AW'(TAPS - 1)) begin
            state_q <= S_CAPT;
            wren_q  <= 1'b0;
            in0_q   <= '0;
            in1_q   <= '0;
          end else begin
            tap_q   <= tap_d;
            wren_q  <= wren_d;
            in0_q   <= samp_q[samp_idx];
            in1_q   <= coef_q[tap_d];
          end
        end
        S_CAPT: begin
          // The MAC has absorbed the last tap at the edge that entered CAPT.
          out_q   <= MacOut_DI;
          valid_q <= 1'b1;
          state_q <= S_OUT;
        end
        S_OUT: begin
          if (OutReady_SI) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
          clr_q   <= 1'b0;
          wren_q  <= 1'b0;
          in0_q   <= '0;
          in1_q   <= '0;
        end
      endcase
    end
  end

  assign InReady_SO  = ready_q;
  assign OutValid_SO = valid_q;
  assign Out_DO      = out_q;
  assign MacClr_SO   = clr_q;
  assign MacWrEn_SO  = wren_q;
  assign MacIn0_DO   = in0_q;
  assign MacIn1_DO   = in1_q;

endmodule
